// File: rtl/vmask_expander_if.sv
// Mask-in / byte-enable-out handshake bundle for vmask_expander.
// The expander uses the master modport; the mask source and byte-enable sink use slave.
interface vmask_expander_if #(
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 64
);
  logic                    mask_valid;
  logic [MASK_WIDTH-1:0]   mask_data;
  logic                    mask_ready;
  logic                    be_valid;
  logic                    be_ready;
  logic [DATA_WIDTH/8-1:0] be_data;
  logic                    be_last;

  modport master (
    input  mask_valid, mask_data, be_ready,
    output mask_ready, be_valid, be_data, be_last
  );

  modport slave (
    output mask_valid, mask_data, be_ready,
    input  mask_ready, be_valid, be_data, be_last
  );
endinterface

// File: rtl/vmask_expander.sv
// Expands a packed element mask into per-byte write enables, one DATA_WIDTH beat per cycle.
// Optional feature: define VMASK_EXPAND_INVERT_EN to add i_mask_invert (invert the fetched mask).
module vmask_expander #(
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = 64,
  parameter int VL_WIDTH   = $clog2(MASK_WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [VL_WIDTH-1:0]  i_vl,
  input  logic [1:0]           i_sew,
  input  logic                 i_vm,
`ifdef VMASK_EXPAND_INVERT_EN
  input  logic                 i_mask_invert,
`endif
  vmask_expander_if.master     bus,
  output logic                 o_busy
);

  localparam int BE     = DATA_WIDTH / 8;
  localparam int LOG2BE = $clog2(BE);
  localparam int MIDX   = $clog2(MASK_WIDTH);
  localparam int EW     = VL_WIDTH + LOG2BE + 1;

  typedef enum logic [1:0] {IDLE, WAIT_MASK, STREAM} state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [VL_WIDTH-1:0]   r_vl;
  logic [1:0]            r_sew;
  logic [MASK_WIDTH-1:0] r_mask;
  logic [VL_WIDTH-1:0]   r_beat;
  logic                  r_be_valid;
  logic [BE-1:0]         r_be_data;
  logic                  r_be_last;

  logic                  w_cfg_load;
  logic                  w_mask_load;
  logic                  w_emit;
  logic                  w_clear_out;
  logic [VL_WIDTH-1:0]   w_emit_beat;
  logic [MASK_WIDTH-1:0] w_mask_src;
  logic [VL_WIDTH-1:0]   w_vl_src;
  logic [1:0]            w_sew_src;
  logic [MASK_WIDTH-1:0] w_mask_in;
  logic [BE-1:0]         w_bytes;
  logic                  w_last;

`ifdef VMASK_EXPAND_INVERT_EN
  logic r_invert;
  assign w_mask_in = bus.mask_data ^ {MASK_WIDTH{r_invert}};
`else
  assign w_mask_in = bus.mask_data;
`endif

  // Byte b belongs to element (c*EPC + b/ESIZE); tail elements at or beyond vl give 0.
  function automatic logic [BE-1:0] beatBytes(input logic [MASK_WIDTH-1:0] m,
                                               input logic [VL_WIDTH-1:0]   n_vl,
                                               input logic [1:0]            s,
                                               input logic [VL_WIDTH-1:0]   c);
    logic [EW-1:0] e;
    beatBytes = '0;
    for (int b = 0; b < BE; b++) begin
      e = (EW'(c) << (LOG2BE - int'(s))) + EW'(b >> s);
      beatBytes[b] = (e < EW'(n_vl)) ? m[e[MIDX-1:0]] : 1'b0;
    end
  endfunction

  function automatic logic beatLast(input logic [VL_WIDTH-1:0] n_vl,
                                    input logic [1:0]          s,
                                    input logic [VL_WIDTH-1:0] c);
    beatLast = ((EW'(c) + EW'(1)) << (LOG2BE - int'(s))) >= EW'(n_vl);
  endfunction

  always_comb begin
    w_next_state = r_state;
    w_cfg_load   = 1'b0;
    w_mask_load  = 1'b0;
    w_emit       = 1'b0;
    w_clear_out  = 1'b0;
    w_emit_beat  = '0;
    w_mask_src   = r_mask;
    w_vl_src     = r_vl;
    w_sew_src    = r_sew;
    case (r_state)
      IDLE: begin
        if (i_start && (i_vl != '0)) begin
          w_cfg_load = 1'b1;
          w_vl_src   = i_vl;
          w_sew_src  = i_sew;
          if (i_vm) begin
            w_mask_src   = '1;
            w_mask_load  = 1'b1;
            w_emit       = 1'b1;
            w_next_state = STREAM;
          end else begin
            w_next_state = WAIT_MASK;
          end
        end
      end
      WAIT_MASK: begin
        if (bus.mask_valid) begin
          w_mask_src   = w_mask_in;
          w_mask_load  = 1'b1;
          w_emit       = 1'b1;
          w_next_state = STREAM;
        end
      end
      STREAM: begin
        if (r_be_valid && bus.be_ready) begin
          if (r_be_last) begin
            w_clear_out  = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_emit      = 1'b1;
            w_emit_beat = r_beat + VL_WIDTH'(1);
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // The next beat is computed from the mask being latched (or the held one) so outputs stay registered.
  assign w_bytes = beatBytes(w_mask_src, w_vl_src, w_sew_src, w_emit_beat);
  assign w_last  = beatLast(w_vl_src, w_sew_src, w_emit_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_vl       <= '0;
      r_sew      <= '0;
      r_mask     <= '0;
      r_beat     <= '0;
      r_be_valid <= 1'b0;
      r_be_data  <= '0;
      r_be_last  <= 1'b0;
`ifdef VMASK_EXPAND_INVERT_EN
      r_invert   <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_cfg_load) begin
        r_vl  <= i_vl;
        r_sew <= i_sew;
`ifdef VMASK_EXPAND_INVERT_EN
        r_invert <= i_mask_invert;
`endif
      end
      if (w_mask_load) begin
        r_mask <= w_mask_src;
      end
      if (w_emit) begin
        r_be_valid <= 1'b1;
        r_be_data  <= w_bytes;
        r_be_last  <= w_last;
        r_beat     <= w_emit_beat;
      end else if (w_clear_out) begin
        r_be_valid <= 1'b0;
        r_be_data  <= '0;
        r_be_last  <= 1'b0;
        r_beat     <= '0;
      end
    end
  end

  assign bus.mask_ready = (r_state == WAIT_MASK);
  assign bus.be_valid   = r_be_valid;
  assign bus.be_data    = r_be_data;
  assign bus.be_last    = r_be_last;
  assign o_busy         = (r_state != IDLE);

endmodule
